// File: rtl/wma_filter_param_if.sv
// wma_filter_param_if: sample, weight-programming and result signals of the weighted moving-average filter.
// coef_addr carries one extra bit so that indices at or beyond TAPS can be presented and ignored.
interface wma_filter_param_if #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int COEF_W = 4
);
    localparam int AW = $clog2(TAPS) + 1;
    logic              in_valid;
    logic [DATA_W-1:0] data_in;
    logic              flush;
    logic              coef_we;
    logic [AW-1:0]     coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              out_valid;
    logic [DATA_W-1:0] data_out;
    logic              sat;
    logic              primed;
    modport master (
        output in_valid, data_in, flush, coef_we, coef_addr, coef_data,
        input  out_valid, data_out, sat, primed
    );
    modport slave (
        input  in_valid, data_in, flush, coef_we, coef_addr, coef_data,
        output out_valid, data_out, sat, primed
    );
endinterface

// File: rtl/wma_filter_param.sv
// wma_filter_param: weighted moving-average FIR with programmable weights, 2-cycle latency and saturating scaling.
// Define WMA_ROUND_EN to round half up before the final shift; otherwise the result is truncated.
module wma_filter_param #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int COEF_W = 4,
    parameter int SHIFT  = 2
) (
    input logic              clk,
    input logic              reset,
    wma_filter_param_if.slave bus
);
    localparam int AW = $clog2(TAPS) + 1;
    localparam int CW = $clog2(TAPS + 1);
    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + $clog2(TAPS);
    localparam int RW = SW + 1;
    localparam logic [RW-1:0] MAX = {{(RW - DATA_W){1'b0}}, {DATA_W{1'b1}}};
`ifdef WMA_ROUND_EN
    localparam logic [RW-1:0] HALF = SHIFT > 0 ? RW'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
`else
    localparam logic [RW-1:0] HALF = '0;
`endif

    logic [DATA_W-1:0] tap  [TAPS];
    logic [COEF_W-1:0] coef [TAPS];
    logic [PW-1:0]     prod [TAPS];
    logic [CW-1:0]     cnt, cnt_nx;
    logic              take, acc_v, prod_v, emit;
    logic [SW-1:0]     sum;
    logic [RW-1:0]     res;

    assign take       = bus.in_valid && !bus.flush;
    assign cnt_nx     = cnt == CW'(TAPS) ? cnt : cnt + 1'b1;
    assign bus.primed = cnt == CW'(TAPS);
    assign emit       = prod_v && !bus.flush;
    assign res        = (RW'(sum) + HALF) >> SHIFT;

    always_comb begin
        sum = '0;
        for (int i = 0; i < TAPS; i++) sum = sum + SW'(prod[i]);
    end

    // Weights survive flush; only reset restores the plain-average default.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= COEF_W'(1);
        end else if (bus.coef_we && bus.coef_addr < AW'(TAPS)) begin
            coef[bus.coef_addr[AW-2:0]] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                tap[i]  <= '0;
                prod[i] <= '0;
            end
            cnt           <= '0;
            acc_v         <= 1'b0;
            prod_v        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.sat       <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) prod[i] <= PW'(tap[i]) * PW'(coef[i]);
            if (bus.flush) begin
                for (int i = 0; i < TAPS; i++) tap[i] <= '0;
                cnt <= '0;
            end else if (bus.in_valid) begin
                tap[0] <= bus.data_in;
                for (int i = 1; i < TAPS; i++) tap[i] <= tap[i-1];
                cnt <= cnt_nx;
            end
            acc_v         <= take && cnt_nx == CW'(TAPS);
            prod_v        <= acc_v && !bus.flush;
            bus.out_valid <= emit;
            if (emit) begin
                bus.data_out <= res > MAX ? '1 : res[DATA_W-1:0];
                bus.sat      <= res > MAX;
            end
        end
    end
endmodule

// File: tb/tb_wma_filter_param.sv
// tb_wma_filter_param: directed table, corner-case sequences and random traffic against a window-sum reference model.
module tb_wma_filter_param;
    localparam int DATA_W = 8;
    localparam int TAPS   = 4;
    localparam int COEF_W = 4;
    localparam int SHIFT  = 2;
    localparam int AW     = $clog2(TAPS) + 1;
    localparam int MAXV   = (1 << DATA_W) - 1;

    typedef struct { int due; int val; bit s; } res_t;
    typedef struct { bit r; bit v; int d; bit ov; int dout; bit s; bit p; } vec_t;

    logic clk = 1'b0;
    logic reset;
    wma_filter_param_if #(.DATA_W(DATA_W), .TAPS(TAPS), .COEF_W(COEF_W)) bus ();
    wma_filter_param #(.DATA_W(DATA_W), .TAPS(TAPS), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0, n_err = 0, cyc = 0;
    int   hist[$];
    int   coef[TAPS];
    res_t pend[$];
    int   got[$];
    bit   exp_ov = 1'b0, exp_s = 1'b0;
    int   exp_d = 0;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge: drive inputs, advance the reference model, check every output.
    task automatic step(input bit r, input bit v, input int d, input bit f, input bit we, input int a, input int cd);
        reset         = r;
        bus.in_valid  = v;
        bus.data_in   = DATA_W'(d);
        bus.flush     = f;
        bus.coef_we   = we;
        bus.coef_addr = AW'(a);
        bus.coef_data = COEF_W'(cd);
        @(posedge clk);
        cyc++;
        if (r) begin
            hist.delete();
            pend.delete();
            foreach (coef[i]) coef[i] = 1;
            exp_d = 0;
            exp_s = 1'b0;
        end else begin
            if (we && a < TAPS) coef[a] = cd;
            if (f) begin
                hist.delete();
                pend.delete();
            end else if (v) begin
                hist.push_front(d);
                if (hist.size() > TAPS) void'(hist.pop_back());
                if (hist.size() == TAPS) begin
                    int acc = 0;
                    for (int i = 0; i < TAPS; i++) acc += hist[i] * coef[i];
`ifdef WMA_ROUND_EN
                    if (SHIFT > 0) acc += 1 << (SHIFT - 1);
`endif
                    acc = acc >> SHIFT;
                    pend.push_back('{cyc + 2, acc > MAXV ? MAXV : acc, acc > MAXV});
                end
            end
        end
        exp_ov = pend.size() > 0 && pend[0].due == cyc;
        if (exp_ov) begin
            exp_d = pend[0].val;
            exp_s = pend[0].s;
            void'(pend.pop_front());
        end
        #1;
        chk("out_valid", int'(bus.out_valid), int'(exp_ov));
        chk("data_out", int'(bus.data_out), exp_d);
        chk("sat", int'(bus.sat), int'(exp_s));
        chk("primed", int'(bus.primed), int'(hist.size() == TAPS));
        if (bus.out_valid) got.push_back(int'(bus.data_out));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int d);
        step(0, 1, d, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0] = '{1, 0, 0,  0, 0,  0, 0};
        tbl[1] = '{0, 1, 4,  0, 0,  0, 0};
        tbl[2] = '{0, 1, 8,  0, 0,  0, 0};
        tbl[3] = '{0, 1, 12, 0, 0,  0, 0};
        tbl[4] = '{0, 1, 16, 0, 0,  0, 1};
        tbl[5] = '{0, 1, 20, 0, 0,  0, 1};
        tbl[6] = '{0, 0, 0,  1, 10, 0, 1};
        tbl[7] = '{0, 0, 0,  1, 14, 0, 1};
        tbl[8] = '{0, 0, 0,  0, 14, 0, 1};
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].r, tbl[k].v, tbl[k].d, 0, 0, 0, 0);
            chk("tbl_out_valid", int'(bus.out_valid), int'(tbl[k].ov));
            chk("tbl_data_out", int'(bus.data_out), tbl[k].dout);
            chk("tbl_sat", int'(bus.sat), int'(tbl[k].s));
            chk("tbl_primed", int'(bus.primed), int'(tbl[k].p));
        end

        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 2);
        step(0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 1, 2, 1);
        step(0, 0, 0, 0, 1, 3, 0);
        got.delete();
        sample(10); sample(20); sample(30); sample(40);
        idle(2);
        chk("weighted_count", got.size(), 1);
`ifdef WMA_ROUND_EN
        chk("weighted_value", got.size() > 0 ? got[0] : -1, 33);
`else
        chk("weighted_value", got.size() > 0 ? got[0] : -1, 32);
`endif

        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) step(0, 0, 0, 0, 1, i, 15);
        for (int i = 0; i < TAPS; i++) sample(255);
        idle(2);
        chk("clip_data", int'(bus.data_out), 255);
        chk("clip_sat", int'(bus.sat), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TAPS; i++) sample(255);
        idle(2);
        chk("noclip_data", int'(bus.data_out), 255);
        chk("noclip_sat", int'(bus.sat), 0);

        step(1, 0, 0, 0, 0, 0, 0);
        got.delete();
        sample(200); sample(200); sample(200);
        step(0, 1, 200, 1, 0, 0, 0);
        chk("flush_primed", int'(bus.primed), 0);
        idle(3);
        chk("flush_no_result", got.size(), 0);
        sample(1); sample(1); sample(1); sample(1);
        idle(3);
        chk("refill_count", got.size(), 1);
        chk("refill_value", got.size() > 0 ? got[0] : -1, 1);

        step(1, 0, 0, 0, 0, 0, 0);
        got.delete();
        foreach (tbl[k]) if (tbl[k].v) begin
            sample(tbl[k].d);
            step(0, 0, 0, 0, 1, 4, 7);
            idle(1);
        end
        idle(3);
        chk("gapped_count", got.size(), 2);
        chk("gapped_first", got.size() > 0 ? got[0] : -1, 10);
        chk("gapped_second", got.size() > 1 ? got[1] : -1, 14);

        step(1, 0, 0, 0, 0, 0, 0);
        got.delete();
        sample(4); sample(8); sample(12); sample(16);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("midreset_out_valid", int'(bus.out_valid), 0);
        chk("midreset_data", int'(bus.data_out), 0);
        chk("midreset_primed", int'(bus.primed), 0);
        idle(4);
        chk("midreset_no_result", got.size(), 0);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, MAXV)),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
